index_stream_collector: RTL and testbench
=========================================

Name: index_stream_collector

Overview:
- Consumer end of the element-index stream produced by the index-update counter, whose outputs are en, value_i and done.
- Captures one data word per valid index into an internal buffer of depth 2**SIZE_ADDR.
- Checks that indices arrive strictly in order, 0..num_elems.
- Once the sequence is complete, exposes the buffer through a 1-cycle-latency read port for the downstream compute stage.

Parameters:
- SIZE_ADDR, 8: index/address width; buffer depth is 2**SIZE_ADDR.
- SIZE_DATA, 32: width of each captured data word.

Ports:
- i_clk  input  1  system clock, rising edge.
- i_rst_n  input  1  asynchronous active-low reset.
- i_num_elems  input  SIZE_ADDR  last valid index; latched on i_start.
- i_start  input  1  single-cycle pulse; (re)arms collection.
- i_en  input  1  index/data valid from the producer.
- i_value_i  input  SIZE_ADDR  index of the current element.
- i_done  input  1  producer flag; marks the final index.
- i_data  input  SIZE_DATA  data word for i_value_i.
- i_rd_en  input  1  read request.
- i_rd_addr  input  SIZE_ADDR  read address.
- o_rd_data  output  SIZE_DATA  read data.
- o_rd_valid  output  1  o_rd_data valid.
- o_busy  output  1  collecting.
- o_full  output  1  complete sequence captured; buffer readable.
- o_err_seq  output  1  sticky sequence error.
- o_count  output  SIZE_ADDR+1  number of elements accepted since the last start.

Behaviour:
- Reset (async, i_rst_n=0):
  - State IDLE.
  - o_busy=0, o_full=0, o_err_seq=0, o_rd_valid=0, o_rd_data=0, o_count=0.
  - Expected-index register=0, latched num_elems=0.
  - Buffer contents are not reset.
- FSM states: IDLE, COLLECT, FULL, ERR.
- i_start in any state, highest priority:
  - Latch i_num_elems, clear the expected index, o_count, o_err_seq and o_full.
  - Go to COLLECT.
  - Any i_en in the same cycle is ignored.
- IDLE: i_en, i_done and i_rd_en are ignored.
- COLLECT (o_busy=1). On i_en=1:
  - If i_value_i == expected:
    - Write buffer[i_value_i] <= i_data.
    - Increment the expected index and o_count.
    - If i_value_i == latched num_elems, go to FULL next cycle (o_busy=0, o_full=1).
  - If i_value_i != expected: no write; go to ERR.
  - If i_done=1 with i_value_i < latched num_elems: go to ERR (early done).
  - Final index with i_done=0: accept it and go to FULL. i_done is only a cross-check.
  - i_en=0 holds state; i_done is ignored when i_en=0.
- FULL:
  - i_rd_en=1 → o_rd_data = buffer[i_rd_addr] and o_rd_valid=1 on the next cycle.
  - o_rd_valid=0 otherwise.
  - i_en is ignored; no overwrite.
- ERR:
  - o_err_seq=1, o_busy=0, o_full=0.
  - Writes are blocked; stays until i_start or reset.
- i_rd_en outside FULL → o_rd_valid=0 next cycle; o_rd_data holds its last value.
- Widths:
  - Element count = num_elems+1, in the range 1..2**SIZE_ADDR.
  - o_count is SIZE_ADDR+1 bits wide, so num_elems = 2**SIZE_ADDR-1 yields count 2**SIZE_ADDR without wrap.
  - Expected-index increment beyond the final index is irrelevant, because the state leaves COLLECT.
- Boundaries:
  - num_elems=0 → a single element; index 0 goes straight to FULL.
  - A read at the same address in the cycle of the final write is not possible (FULL is entered after the write).
  - Reset mid-COLLECT → IDLE with all outputs at their reset values.

Decomposition:
- Package index_collector_pkg holds:
  - The state enum typedef (IDLE, COLLECT, FULL, ERR).
  - The default SIZE_ADDR/SIZE_DATA localparams.
- Sub-module collector_buffer_ram is a simple single-port-write/single-port-read synchronous RAM, with depth 2**SIZE_ADDR and registered read.
- The FSM, index check and counters live in the top module.

Test Plan:
- Normal sequence: start with i_num_elems=4; indices 0..4 with data 0xA0..0xA4, i_done on index 4.
  - Response: o_busy=1 during capture; o_full=1 and o_count=5 the cycle after index 4.
  - Reading addresses 0..4 returns 0xA0..0xA4 with o_rd_valid one cycle after each i_rd_en.
- Stalled producer: num_elems=31, i_en dropped for 10 cycles mid-stream at index 12.
  - Response: o_count holds at 12, no state change; completes with o_count=32 and o_full=1.
- Out-of-order: num_elems=7; indices 0,1,3.
  - Response: o_err_seq=1 the cycle after index 3, o_count=2, buffer[3] unchanged.
  - Further i_en pulses are ignored until i_start.
- Early done: num_elems=7; i_done with index 5.
  - Response: ERR, o_err_seq=1, o_full=0.
- Restart and reset: a second i_start mid-COLLECT at o_count=3 clears o_count to 0 and recollects from index 0. A separate run with i_rst_n=0 mid-stream returns all outputs to 0 asynchronously.
- Edge sizes and stray reads:
  - num_elems=0 with a single index 0 → o_full=1, o_count=1.
  - num_elems=255 → o_count=256, no wrap.
  - i_rd_en in IDLE/COLLECT → o_rd_valid stays 0.

Source files
------------

// File: rtl/index_collector_pkg.sv
// index_collector_pkg: shared state type and default widths for the index stream collector.
package index_collector_pkg;
  localparam int DEF_SIZE_ADDR = 8;
  localparam int DEF_SIZE_DATA = 32;
  typedef enum logic [1:0] {IDLE, COLLECT, FULL, ERR} state_e;
endpackage

// File: rtl/collector_buffer_ram.sv
// collector_buffer_ram: single-write/single-read synchronous RAM with registered, resettable read data.
module collector_buffer_ram #(
  parameter int SIZE_ADDR = 8,
  parameter int SIZE_DATA = 32
) (
  input  logic                 i_clk,
  input  logic                 i_rst_n,
  input  logic                 i_we,
  input  logic [SIZE_ADDR-1:0] i_waddr,
  input  logic [SIZE_DATA-1:0] i_wdata,
  input  logic                 i_re,
  input  logic [SIZE_ADDR-1:0] i_raddr,
  output logic [SIZE_DATA-1:0] o_rdata
);
  logic [SIZE_DATA-1:0] mem [2**SIZE_ADDR];
  logic [SIZE_DATA-1:0] rdata_q, rdata_d;
  always_ff @(posedge i_clk)
    if (i_we) mem[i_waddr] <= i_wdata;
  always_comb rdata_d = i_re ? mem[i_raddr] : rdata_q;
  always_ff @(posedge i_clk or negedge i_rst_n)
    if (!i_rst_n) rdata_q <= '0;
    else rdata_q <= rdata_d;
  assign o_rdata = rdata_q;
endmodule

// File: rtl/index_stream_collector.sv
// index_stream_collector: captures an in-order index/data stream into a buffer,
// flags sequence errors, and exposes the buffer for reading once complete.
module index_stream_collector
  import index_collector_pkg::*;
#(
  parameter int SIZE_ADDR = DEF_SIZE_ADDR,
  parameter int SIZE_DATA = DEF_SIZE_DATA
) (
  input  logic                 i_clk,
  input  logic                 i_rst_n,
  input  logic [SIZE_ADDR-1:0] i_num_elems,
  input  logic                 i_start,
  input  logic                 i_en,
  input  logic [SIZE_ADDR-1:0] i_value_i,
  input  logic                 i_done,
  input  logic [SIZE_DATA-1:0] i_data,
  input  logic                 i_rd_en,
  input  logic [SIZE_ADDR-1:0] i_rd_addr,
  output logic [SIZE_DATA-1:0] o_rd_data,
  output logic                 o_rd_valid,
  output logic                 o_busy,
  output logic                 o_full,
  output logic                 o_err_seq,
  output logic [SIZE_ADDR:0]   o_count
);
  state_e               state_q, state_d;
  logic [SIZE_ADDR-1:0] num_q, num_d, exp_q, exp_d;
  logic [SIZE_ADDR:0]   cnt_q, cnt_d;
  logic                 busy_q, full_q, err_q, rd_valid_q;
  logic                 hit, early_done, we, re;
  assign hit        = state_q == COLLECT && i_en && i_value_i == exp_q;
  assign early_done = i_done && i_value_i < num_q;
  assign we         = !i_start && hit && !early_done;
  assign re         = i_rd_en && state_q == FULL;
  always_comb begin
    state_d = state_q;
    num_d   = num_q;
    exp_d   = exp_q;
    cnt_d   = cnt_q;
    if (i_start) begin
      state_d = COLLECT;
      num_d   = i_num_elems;
      exp_d   = '0;
      cnt_d   = '0;
    end else if (state_q == COLLECT && i_en) begin
      state_d = we ? (i_value_i == num_q ? FULL : COLLECT) : ERR;
      exp_d   = we ? exp_q + SIZE_ADDR'(1) : exp_q;
      cnt_d   = we ? cnt_q + (SIZE_ADDR+1)'(1) : cnt_q;
    end
  end
  // Status flags are registered from the next state so they line up with state_q.
  always_ff @(posedge i_clk or negedge i_rst_n)
    if (!i_rst_n) begin
      state_q    <= IDLE;
      num_q      <= '0;
      exp_q      <= '0;
      cnt_q      <= '0;
      busy_q     <= 1'b0;
      full_q     <= 1'b0;
      err_q      <= 1'b0;
      rd_valid_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      num_q      <= num_d;
      exp_q      <= exp_d;
      cnt_q      <= cnt_d;
      busy_q     <= state_d == COLLECT;
      full_q     <= state_d == FULL;
      err_q      <= state_d == ERR;
      rd_valid_q <= re;
    end
  collector_buffer_ram #(.SIZE_ADDR(SIZE_ADDR), .SIZE_DATA(SIZE_DATA)) u_ram (
    .i_clk   (i_clk),
    .i_rst_n (i_rst_n),
    .i_we    (we),
    .i_waddr (i_value_i),
    .i_wdata (i_data),
    .i_re    (re),
    .i_raddr (i_rd_addr),
    .o_rdata (o_rd_data)
  );
  assign o_rd_valid = rd_valid_q;
  assign o_busy     = busy_q;
  assign o_full     = full_q;
  assign o_err_seq  = err_q;
  assign o_count    = cnt_q;
endmodule

// File: tb/tb_index_stream_collector.sv
// tb_index_stream_collector: directed stimulus, per-cycle check against a count-based reference model.
module tb_index_stream_collector;
  logic        clk = 0, rst_n = 0;
  logic [7:0]  num_elems = 0, value_i = 0, rd_addr = 0;
  logic        start = 0, en = 0, done = 0, rd_en = 0;
  logic [31:0] data = 0, rd_data;
  logic        rd_valid, busy, full, err_seq;
  logic [8:0]  count;
  int tot = 0, bad = 0;

  index_stream_collector dut (
    .i_clk(clk), .i_rst_n(rst_n), .i_num_elems(num_elems), .i_start(start),
    .i_en(en), .i_value_i(value_i), .i_done(done), .i_data(data),
    .i_rd_en(rd_en), .i_rd_addr(rd_addr), .o_rd_data(rd_data), .o_rd_valid(rd_valid),
    .o_busy(busy), .o_full(full), .o_err_seq(err_seq), .o_count(count)
  );

  always #5 clk = ~clk;

  // Reference: the next expected index is simply the number of accepted elements.
  int          m_mode = 0, m_num = 0, m_cnt = 0;
  logic [31:0] m_buf [256];
  logic [31:0] m_rdd = 0;
  logic        m_rdv = 0;
  always @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      m_mode = 0; m_num = 0; m_cnt = 0; m_rdd = 0; m_rdv = 0;
    end else begin
      m_rdv = rd_en && m_mode == 2;
      if (m_rdv) m_rdd = m_buf[rd_addr];
      if (start) begin
        m_mode = 1; m_num = int'(num_elems); m_cnt = 0;
      end else if (m_mode == 1 && en) begin
        if (int'(value_i) == m_cnt && !(done && int'(value_i) < m_num)) begin
          m_buf[value_i] = data;
          m_cnt++;
          if (m_cnt == m_num + 1) m_mode = 2;
        end else m_mode = 3;
      end
    end

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    tot++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s act=%0h exp=%0h t=%0t", nm, act, exp, $time);
    end
  endtask

  always @(negedge clk)
    if (rst_n) begin
      chk("busy", 64'(busy), 64'(m_mode == 1));
      chk("full", 64'(full), 64'(m_mode == 2));
      chk("err_seq", 64'(err_seq), 64'(m_mode == 3));
      chk("count", 64'(count), 64'(m_cnt));
      chk("rd_valid", 64'(rd_valid), 64'(m_rdv));
      chk("rd_data", 64'(rd_data), 64'(m_rdd));
    end

  task automatic cyc(); @(negedge clk); endtask
  task automatic do_start(input logic [7:0] n);
    start = 1; num_elems = n; cyc(); start = 0;
  endtask
  task automatic send(input int idx, input logic [31:0] d, input logic dn);
    en = 1; value_i = 8'(idx); data = d; done = dn; cyc(); en = 0; done = 0;
  endtask
  task automatic rd(input int a);
    rd_en = 1; rd_addr = 8'(a); cyc(); rd_en = 0;
  endtask

  initial begin
    repeat (3) cyc();
    rst_n = 1;
    cyc();
    chk("lit_reset_busy", 64'(busy), 0);
    chk("lit_reset_count", 64'(count), 0);
    rd(0);
    chk("lit_idle_rd_valid", 64'(rd_valid), 0);
    // normal sequence
    do_start(4);
    chk("lit_busy", 64'(busy), 1);
    for (int i = 0; i <= 4; i++) send(i, 32'hA0 + i, i == 4);
    chk("lit_full5", 64'(full), 1);
    chk("lit_count5", 64'(count), 5);
    for (int i = 0; i <= 4; i++) begin
      rd(i);
      chk("lit_rd_valid", 64'(rd_valid), 1);
      chk("lit_rd_data", 64'(rd_data), 64'(32'hA0 + i));
    end
    cyc();
    chk("lit_rd_valid_drop", 64'(rd_valid), 0);
    chk("lit_rd_data_hold", 64'(rd_data), 64'hA4);
    // stalled producer with a stray read during collection
    do_start(31);
    for (int i = 0; i < 12; i++) send(i, 32'h300 + i, 0);
    rd(3);
    chk("lit_collect_rd_valid", 64'(rd_valid), 0);
    repeat (9) cyc();
    chk("lit_stall_count", 64'(count), 12);
    chk("lit_stall_busy", 64'(busy), 1);
    for (int i = 12; i <= 31; i++) send(i, 32'h300 + i, i == 31);
    chk("lit_count32", 64'(count), 32);
    chk("lit_full32", 64'(full), 1);
    // out of order
    do_start(7);
    send(0, 32'hB0, 0); send(1, 32'hB1, 0); send(3, 32'hB3, 0);
    chk("lit_ooo_err", 64'(err_seq), 1);
    chk("lit_ooo_count", 64'(count), 2);
    send(2, 32'hB2, 0); send(3, 32'hB3, 0);
    chk("lit_ooo_sticky", 64'(err_seq), 1);
    chk("lit_ooo_count_hold", 64'(count), 2);
    do_start(2);
    for (int i = 0; i <= 2; i++) send(i, 32'hC0 + i, i == 2);
    rd(3);
    chk("lit_buf3_unchanged", 64'(rd_data), 64'h303);
    // early done
    do_start(7);
    for (int i = 0; i < 5; i++) send(i, 32'hD0 + i, 0);
    send(5, 32'hD5, 1);
    chk("lit_early_err", 64'(err_seq), 1);
    chk("lit_early_full", 64'(full), 0);
    // restart mid-collection
    do_start(7);
    for (int i = 0; i < 3; i++) send(i, 32'hE0 + i, 0);
    chk("lit_pre_restart", 64'(count), 3);
    do_start(7);
    chk("lit_restart_count", 64'(count), 0);
    for (int i = 0; i <= 7; i++) send(i, 32'hF0 + i, i == 7);
    chk("lit_restart_full", 64'(full), 1);
    rd(6);
    chk("lit_restart_rd", 64'(rd_data), 64'hF6);
    // asynchronous reset mid-stream
    do_start(7);
    send(0, 32'h10, 0); send(1, 32'h11, 0);
    #2 rst_n = 0;
    #1;
    chk("lit_arst_busy", 64'(busy), 0);
    chk("lit_arst_count", 64'(count), 0);
    chk("lit_arst_rd_data", 64'(rd_data), 0);
    chk("lit_arst_err", 64'(err_seq), 0);
    cyc();
    rst_n = 1;
    cyc();
    // single element
    do_start(0);
    send(0, 32'h55, 1);
    chk("lit_single_full", 64'(full), 1);
    chk("lit_single_count", 64'(count), 1);
    rd(0);
    chk("lit_single_rd", 64'(rd_data), 64'h55);
    // full depth, no count wrap
    do_start(255);
    for (int i = 0; i <= 255; i++) send(i, 32'h1000 + i, i == 255);
    chk("lit_count256", 64'(count), 256);
    chk("lit_full256", 64'(full), 1);
    rd(255);
    chk("lit_rd255", 64'(rd_data), 64'h10FF);
    cyc();
    $display("test done: total=%0d bad=%0d", tot, bad);
    $finish;
  end
endmodule
